// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity modes and bit-period helper
package uart_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;
    function automatic int clk_per_bit(input int clock_hz, input int baud_rate);
        return clock_hz / baud_rate;
    endfunction
endpackage

// File: rtl/uart_tx_baud_gen.sv
// uart_baud_gen: bit-period counter with clear/enable and end-of-bit strobes
module uart_baud_gen #(
    parameter int CLK_P_BIT = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_bit_end,
    output logic o_pre_end
);
    localparam int CW = $clog2(CLK_P_BIT) + 1;
    logic [CW-1:0] r_cnt;
    assign o_bit_end = i_en && r_cnt == CW'(CLK_P_BIT - 1);
    // one cycle early so a registered strobe can land on the last cycle of a bit
    assign o_pre_end = i_en && r_cnt == CW'(CLK_P_BIT - 2);
    always_ff @(posedge clk) begin
        if (reset || i_clear)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= o_bit_end ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises one word per request as start, LSB-first data, optional parity, stop bits
module uart_tx
    import uart_pkg::*;
#(
    parameter int N_BITS    = 8,
    parameter int BAUD_RATE = 9600,
    parameter int CLOCK_HZ  = 50_000_000,
    parameter int STOP_BITS = 1,
    parameter int PARITY    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_BITS-1:0] data,
    output logic              txd,
    output logic              busy,
    output logic              done
);
    localparam int CLK_P_BIT = clk_per_bit(CLOCK_HZ, BAUD_RATE);
    localparam logic [4:0] LAST_BIT = 5'(N_BITS - 1);
    localparam logic [4:0] LAST_STOP = 5'(STOP_BITS - 1);
    localparam bit HAS_PAR = PARITY != PARITY_NONE;
    if (N_BITS < 1 || N_BITS > 16 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY < 0 || PARITY > 2 || CLK_P_BIT < 2) begin : g_bad_param
        $error("uart_tx: unsupported parameter combination");
    end
    logic [2:0]        r_state;
    logic [N_BITS-1:0] r_shift;
    logic [4:0]        r_idx;
    logic              r_par;
    logic              r_txd;
    logic              r_busy;
    logic              r_done;
    logic [N_BITS-1:0] w_shift_nxt;
    logic              w_bit_end;
    logic              w_pre_end;
    assign w_shift_nxt = r_shift >> 1;
    assign txd  = r_txd;
    assign busy = r_busy;
    assign done = r_done;
    uart_baud_gen #(.CLK_P_BIT(CLK_P_BIT)) u_baud (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (r_state == S_IDLE),
        .i_en      (r_state != S_IDLE),
        .o_bit_end (w_bit_end),
        .o_pre_end (w_pre_end)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= r_state == S_STOP && r_idx == LAST_STOP && w_pre_end;
            case (r_state)
                S_IDLE: if (start) begin
                    r_shift <= data;
                    r_par   <= ^data ^ (PARITY == PARITY_ODD);
                    r_idx   <= '0;
                    r_txd   <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= S_START;
                end
                S_START: if (w_bit_end) begin
                    r_txd   <= r_shift[0];
                    r_state <= S_DATA;
                end
                S_DATA: if (w_bit_end) begin
                    r_shift <= w_shift_nxt;
                    if (r_idx == LAST_BIT) begin
                        r_idx   <= '0;
                        r_txd   <= HAS_PAR ? r_par : 1'b1;
                        r_state <= HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                        r_txd <= w_shift_nxt[0];
                    end
                end
                S_PARITY: if (w_bit_end) begin
                    r_idx   <= '0;
                    r_txd   <= 1'b1;
                    r_state <= S_STOP;
                end
                S_STOP: if (w_bit_end) begin
                    if (r_idx == LAST_STOP) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else
                        r_idx <= r_idx + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
